// File: rtl/packet_check_if.sv
// AXI-Stream bundle between the FIFO under test and the packet checker.
interface packet_check_if #(
    parameter int DW = 512
) ();
    logic [DW-1:0]   tdata;
    logic [DW/8-1:0] tkeep;
    logic            tlast;
    logic            tvalid;
    logic            tready;

    modport master (
        output tdata, tkeep, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/packet_check.sv
// AXI-Stream sink that checks the packet generator's test stream
// beat by beat and counts packets and errored beats.
module packet_check #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          throttle,
    packet_check_if.slave axis_in,
    output logic [31:0]   pkt_count,
    output logic [15:0]   err_count,
    output logic [3:0]    err_flags,
    output logic          busy
);
    localparam int DB = DW / 8;
    localparam int LB = $clog2(DB);

    typedef enum logic {
        IDLE,
        CHECK
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [15:0]   lfsr;
    logic [15:0]   exp_data;
    logic [15:0]   cycle;
    logic [2:0]    plen_idx;
    logic [15:0]   len;
    logic [15:0]   beats;
    logic [15:0]   part;
    logic          exp_last;
    logic          accept;
    logic [DB-1:0] keep_exp;
    logic [3:0]    err;
    logic          lfsr_fb;

    always_comb begin
        len = 16'd0;
        unique case (plen_idx)
            3'd0: len = 16'd18;
            3'd1: len = 16'd128;
            3'd2: len = 16'd1021;
            3'd3: len = 16'd205;
            3'd4: len = 16'd12;
            3'd5: len = 16'd127;
            3'd6: len = 16'd329;
            3'd7: len = 16'd256;
        endcase
    end

    assign beats    = (len + 16'(DB - 1)) >> LB;
    assign part     = len & 16'(DB - 1);
    assign exp_last = (cycle == beats);

    always_comb begin
        keep_exp = '1;
        if (exp_last && part != 16'd0)
            keep_exp = ~({DB{1'b1}} << part);
    end

    assign axis_in.tready = (state == CHECK)
                          && (!throttle || lfsr[0]);
    assign accept = axis_in.tvalid && axis_in.tready;

    always_comb begin
        err    = 4'd0;
        err[0] = axis_in.tdata != {(DW/16){exp_data}};
        err[1] = axis_in.tkeep != keep_exp;
        err[2] = axis_in.tlast && (cycle < beats);
        err[3] = !axis_in.tlast && (cycle >= beats);
    end

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = CHECK;
            CHECK: state_n = CHECK;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr      <= 16'hACE1;
            exp_data  <= 16'd1;
            cycle     <= 16'd1;
            plen_idx  <= 3'd0;
            pkt_count <= 32'd0;
            err_count <= 16'd0;
            err_flags <= 4'd0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_n == CHECK);
            if (state == IDLE && start) begin
                exp_data <= 16'd1;
                plen_idx <= 3'd0;
                cycle    <= 16'd1;
            end
            if (state == CHECK)
                lfsr <= {lfsr_fb, lfsr[15:1]};
            if (accept) begin
                if (err != 4'd0) begin
                    if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'd1;
                    err_flags <= err_flags | err;
                end
                // a data error resyncs to whatever the sender is on
                if (err[0])
                    exp_data <= axis_in.tdata[15:0] + 16'd1;
                else
                    exp_data <= exp_data + 16'd1;
                if (axis_in.tlast) begin
                    pkt_count <= pkt_count + 32'd1;
                    cycle     <= 16'd1;
                    plen_idx  <= plen_idx + 3'd1;
                end else if (cycle != 16'hFFFF) begin
                    cycle <= cycle + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_packet_check.sv
// Randomised scoreboard bench for packet_check: generator model,
// behavioural checker model and a decoupled output monitor.
module tb_packet_check;
    localparam int DW = 512;
    localparam int DB = DW / 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        throttle;
    logic [31:0] pkt_count;
    logic [15:0] err_count;
    logic [3:0]  err_flags;
    logic        busy;

    packet_check_if #(.DW(DW)) axis_in ();

    packet_check #(.DW(DW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .throttle  (throttle),
        .axis_in   (axis_in),
        .pkt_count (pkt_count),
        .err_count (err_count),
        .err_flags (err_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pkt;
        logic [15:0] errc;
        logic [3:0]  flags;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    int   LEN[8] = '{18, 128, 1021, 205, 12, 127, 329, 256};

    // checker reference model
    logic [15:0] m_exp;
    int          m_idx;
    int          m_cyc;
    logic [31:0] m_pkt;
    int          m_err;
    logic [3:0]  m_flags;

    // generator state
    logic [15:0] g_data;
    int          g_idx;
    int          g_beat;
    int          corrupt_at = 0;
    logic [15:0] corrupt_val = 16'h0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_beat(input logic [DW-1:0] d,
                              input logic [DB-1:0] k, input logic l);
        int            len;
        int            nb;
        int            part;
        bit            lastb;
        logic [DB-1:0] kexp;
        logic [3:0]    e;
        exp_t          x;
        len   = LEN[m_idx];
        nb    = (len + DB - 1) / DB;
        part  = len % DB;
        lastb = (m_cyc == nb);
        for (int i = 0; i < DB; i++)
            kexp[i] = !(lastb && part != 0) || (i < part);
        e[0] = (d != {(DW/16){m_exp}});
        e[1] = (k != kexp);
        e[2] = l && (m_cyc < nb);
        e[3] = !l && (m_cyc >= nb);
        if (e != 4'd0) begin
            if (m_err < 65535) m_err++;
            m_flags = m_flags | e;
        end
        m_exp = e[0] ? d[15:0] + 16'd1 : m_exp + 16'd1;
        if (l) begin
            m_pkt++;
            m_cyc = 1;
            m_idx = (m_idx + 1) % 8;
        end else if (m_cyc < 65535) begin
            m_cyc++;
        end
        x.pkt   = m_pkt;
        x.errc  = 16'(m_err);
        x.flags = m_flags;
        q.push_back(x);
    endtask

    task automatic send_beat(input logic [DW-1:0] d,
                             input logic [DB-1:0] k,
                             input logic l, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        axis_in.tdata  = d;
        axis_in.tkeep  = k;
        axis_in.tlast  = l;
        axis_in.tvalid = 1'b1;
        forever begin
            #1;
            if (axis_in.tready) begin
                model_beat(d, k, l);
                break;
            end
            stalls++;
            n++;
            if (n > 1000) begin
                axis_in.tvalid = 1'b0;
                checks++;
                errors++;
                $display("FAIL beat_timeout: tready low %0d cycles, need 1", n);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        axis_in.tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int nb_send, input bit bad_keep,
                            input bit no_last, input bit gaps,
                            input bit rnd_err);
        int            len;
        int            nb;
        int            part;
        logic [15:0]   w;
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        len  = LEN[g_idx];
        nb   = (len + DB - 1) / DB;
        part = len % DB;
        if (nb_send == 0) nb_send = nb;
        for (int b = 1; b <= nb_send; b++) begin
            k = '1;
            if (b == nb && part != 0 && !bad_keep)
                for (int i = 0; i < DB; i++) k[i] = (i < part);
            w = (g_beat == corrupt_at) ? corrupt_val : g_data;
            d = {(DW/16){w}};
            if (rnd_err && $urandom_range(0, 19) == 0)
                d[$urandom_range(0, DW - 1)] ^= 1'b1;
            if (rnd_err && $urandom_range(0, 19) == 0)
                k[$urandom_range(0, DB - 1)] ^= 1'b1;
            send_beat(d, k, (b == nb_send) && !no_last, gaps);
            g_data = w + 16'd1;
            g_beat++;
        end
        g_idx = (g_idx + 1) % 8;
    endtask

    task automatic start_check();
        m_exp  = 16'd1;
        m_idx  = 0;
        m_cyc  = 1;
        g_data = 16'd1;
        g_idx  = 0;
        g_beat = 1;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic do_reset();
        axis_in.tvalid = 1'b0;
        repeat (2) @(negedge clk);
        resetn  = 1'b0;
        q.delete();
        m_pkt   = 32'd0;
        m_err   = 0;
        m_flags = 4'd0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        axis_in.tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic chk_totals(input string t, input logic [31:0] p,
                              input logic [15:0] e, input logic [3:0] f);
        chk({t, "_pkt_count"}, 64'(pkt_count), 64'(p));
        chk({t, "_err_count"}, 64'(err_count), 64'(e));
        chk({t, "_err_flags"}, 64'(err_flags), 64'(f));
    endtask

    // monitor: compares outputs one edge after each accepted beat
    initial begin
        bit   acc_prev = 1'b0;
        exp_t x;
        forever begin
            @(negedge clk);
            if (acc_prev) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: beat accepted, need none");
                end else begin
                    x = q.pop_front();
                    chk("sb_pkt_count", 64'(pkt_count), 64'(x.pkt));
                    chk("sb_err_count", 64'(err_count), 64'(x.errc));
                    chk("sb_err_flags", 64'(err_flags), 64'(x.flags));
                end
            end
            #2;
            acc_prev = resetn && axis_in.tvalid && axis_in.tready;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: run did not finish, need $finish");
        $fatal(1);
    end

    initial begin
        resetn         = 1'b0;
        start          = 1'b0;
        throttle       = 1'b0;
        axis_in.tvalid = 1'b0;
        axis_in.tdata  = '0;
        axis_in.tkeep  = '0;
        axis_in.tlast  = 1'b0;
        m_pkt          = 32'd0;
        m_err          = 0;
        m_flags        = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_tready", 64'(axis_in.tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_totals("rst", 32'd0, 16'd0, 4'd0);
        resetn = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        do_reset();

        // clean stream, full tready
        start_check();
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_tready", 64'(axis_in.tready), 64'd1);
        stalls = 0;
        for (int p = 0; p < 8; p++) send_pkt(0, 0, 0, 0, 0);
        drain();
        chk_totals("t1", 32'd8, 16'd0, 4'd0);
        chk("t1_no_stall", 64'(stalls), 64'd0);

        // LFSR backpressure
        do_reset();
        throttle = 1'b1;
        start_check();
        stalls = 0;
        for (int p = 0; p < 64; p++) send_pkt(0, 0, 0, 0, 0);
        drain();
        chk_totals("t2", 32'd64, 16'd0, 4'd0);
        chk("t2_backpressure", 64'(stalls > 0), 64'd1);
        throttle = 1'b0;

        // data corruption with resync
        do_reset();
        corrupt_at  = 3;
        corrupt_val = 16'h0055;
        start_check();
        for (int p = 0; p < 8; p++) send_pkt(0, 0, 0, 0, 0);
        drain();
        chk_totals("t3", 32'd8, 16'd1, 4'b0001);
        corrupt_at = 0;

        // wrong tkeep on the 1021-byte packet
        do_reset();
        start_check();
        send_pkt(0, 0, 0, 0, 0);
        send_pkt(0, 0, 0, 0, 0);
        send_pkt(0, 1, 0, 0, 0);
        drain();
        chk_totals("t4", 32'd3, 16'd1, 4'b0010);

        // early and missing tlast
        do_reset();
        start_check();
        send_pkt(0, 0, 0, 0, 0);
        send_pkt(1, 0, 0, 0, 0);
        send_pkt(17, 0, 0, 0, 0);
        drain();
        chk_totals("t5", 32'd3, 16'd2, 4'b1100);

        // reset mid-packet then clean restart
        do_reset();
        start_check();
        send_pkt(0, 0, 0, 0, 0);
        send_pkt(0, 0, 0, 0, 0);
        send_pkt(5, 0, 1, 0, 0);
        do_reset();
        chk_totals("t6_rst", 32'd0, 16'd0, 4'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_tready", 64'(axis_in.tready), 64'd0);
        start_check();
        for (int p = 0; p < 8; p++) send_pkt(0, 0, 0, 0, 0);
        drain();
        chk_totals("t6", 32'd8, 16'd0, 4'd0);

        // resync onto FFFF, then sequence wraps to 0000
        do_reset();
        corrupt_at  = 1;
        corrupt_val = 16'hFFFF;
        start_check();
        for (int p = 0; p < 3; p++) send_pkt(0, 0, 0, 0, 0);
        drain();
        chk_totals("t8", 32'd3, 16'd1, 4'b0001);
        corrupt_at = 0;

        // random gaps, throttle and corruption
        do_reset();
        start_check();
        for (int p = 0; p < 24; p++) begin
            throttle = 1'($urandom_range(0, 1));
            send_pkt(0, 0, 0, 1, 1);
        end
        drain();
        chk_totals("t7", m_pkt, 16'(m_err), m_flags);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
